// File: rtl/ahb_slave_mux.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux
// AHB response-side multiplexer and default slave. Registers the decoder's
// address-phase one-hot select into a data-phase select, routes the selected
// slave's HRDATA/HREADYOUT/HRESP back to the master, and issues the two-cycle
// ERROR response for unmapped accesses and for slaves that stall too long.
//
// Ports
//   bus_clk_in         HCLK
//   bus_rstn_in        asynchronous active-low reset
//   slave_sel_in       address-phase one-hot select (all-zero = unmapped)
//   htrans_in          HTRANS of the current address phase
//   slave_rdata_in     packed per-slave HRDATA, slave i at [i*W +: W]
//   slave_ready_in     per-slave HREADYOUT
//   slave_resp_in      per-slave HRESP (1 = ERROR)
//   master_rdata_out   HRDATA to the master
//   master_ready_out   HREADY to the master and all slaves
//   master_resp_out    HRESP to the master
//   data_sel_out       registered data-phase one-hot select
//   timeout_pulse_out  one-cycle pulse when a wait-state timeout fires
// ---------------------------------------------------------------------------
module ahb_slave_mux #(
   parameter int unsigned AHB_DATA_WIDTH = 32,
   parameter int unsigned SLAVE_DEVICES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                                    bus_clk_in,
   input  logic                                    bus_rstn_in,
   input  logic [SLAVE_DEVICES-1:0]                slave_sel_in,
   input  logic [1:0]                              htrans_in,
   input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in,
   input  logic [SLAVE_DEVICES-1:0]                slave_ready_in,
   input  logic [SLAVE_DEVICES-1:0]                slave_resp_in,
   output logic [AHB_DATA_WIDTH-1:0]               master_rdata_out,
   output logic                                    master_ready_out,
   output logic                                    master_resp_out,
   output logic [SLAVE_DEVICES-1:0]                data_sel_out,
   output logic                                    timeout_pulse_out
);

   // Counter is kept at least one bit wide so a disabled timeout still elaborates.
   localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      IDLE_DP  = 2'd0,
      SLAVE_DP = 2'd1,
      ERR1     = 2'd2,
      ERR2     = 2'd3
   } state_e;

   state_e                     state_q, state_d;
   logic [SLAVE_DEVICES-1:0]   data_sel_q, data_sel_d;
   logic [CNT_W-1:0]           wait_cnt_q, wait_cnt_d;
   logic                       pulse_q, pulse_d;

   logic [AHB_DATA_WIDTH-1:0]  sel_rdata;
   logic                       sel_ready;
   logic                       sel_resp;
   logic                       is_transfer;
   logic [SLAVE_DEVICES-1:0]   sel_lowest;

   // One-hot select makes the AND-OR mux equivalent to an indexed mux.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < int'(SLAVE_DEVICES); i++) begin
         if (data_sel_q[i]) begin
            sel_rdata = sel_rdata | slave_rdata_in[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
         end
      end
   end

   assign sel_ready   = |(data_sel_q & slave_ready_in);
   assign sel_resp    = |(data_sel_q & slave_resp_in);
   assign is_transfer = (htrans_in == 2'b10) || (htrans_in == 2'b11);
   // Isolate lowest set bit: multi-hot selects resolve to the lowest index.
   assign sel_lowest  = slave_sel_in & (~slave_sel_in + SLAVE_DEVICES'(1));

   // Response decode, combinational from state and data-phase select.
   always_comb begin
      master_rdata_out = '0;
      master_ready_out = 1'b1;
      master_resp_out  = 1'b0;
      case (state_q)
         SLAVE_DP: begin
            master_rdata_out = sel_rdata;
            master_ready_out = sel_ready;
            master_resp_out  = sel_resp;
         end
         ERR1: begin
            master_ready_out = 1'b0;
            master_resp_out  = 1'b1;
         end
         ERR2: begin
            master_resp_out  = 1'b1;
         end
         default: ;
      endcase
   end

   // Next-state: error sequencing, wait-state timeout, address sampling.
   always_comb begin
      state_d    = state_q;
      data_sel_d = data_sel_q;
      wait_cnt_d = wait_cnt_q;
      pulse_d    = 1'b0;
      if (state_q == ERR1) begin
         state_d    = ERR2;
         data_sel_d = '0;
      end else if ((state_q == SLAVE_DP) && !sel_ready) begin
         if ((TIMEOUT_CYCLES > 0) && (wait_cnt_q == CNT_W'(TO_LAST))) begin
            state_d    = ERR1;
            data_sel_d = '0;
            wait_cnt_d = '0;
            pulse_d    = 1'b1;
         end else if (TIMEOUT_CYCLES > 0) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
         end
      end else begin
         // HREADY is high here: the current address phase completes.
         if (!is_transfer) begin
            state_d    = IDLE_DP;
            data_sel_d = '0;
         end else if (|slave_sel_in) begin
            state_d    = SLAVE_DP;
            data_sel_d = sel_lowest;
            wait_cnt_d = '0;
         end else begin
            state_d    = ERR1;
            data_sel_d = '0;
         end
      end
   end

   always_ff @(posedge bus_clk_in or negedge bus_rstn_in) begin
      if (!bus_rstn_in) begin
         state_q    <= IDLE_DP;
         data_sel_q <= '0;
         wait_cnt_q <= '0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_sel_q <= data_sel_d;
         wait_cnt_q <= wait_cnt_d;
         pulse_q    <= pulse_d;
      end
   end

   assign data_sel_out      = data_sel_q;
   assign timeout_pulse_out = pulse_q;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mux
// Directed scenarios followed by randomized traffic, checked every cycle
// against a transaction-level reference model (pending error cycles, selected
// slave index, stall count).
// ---------------------------------------------------------------------------
module tb_ahb_slave_mux;

   localparam int unsigned DW = 32;
   localparam int unsigned NS = 4;
   localparam int unsigned TO = 16;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NS-1:0]     sel;
   logic [1:0]        htrans;
   logic [NS*DW-1:0]  rdata_bus;
   logic [NS-1:0]     rdy;
   logic [NS-1:0]     rsp;
   logic [DW-1:0]     m_rdata;
   logic              m_ready;
   logic              m_resp;
   logic [NS-1:0]     d_sel;
   logic              to_pulse;

   int errors = 0;
   int checks = 0;

   // Reference model: pending error cycles (2,1,0), active slave (-1 none), stalls.
   int m_err_left;
   int m_idx;
   int m_waits;
   bit m_pulse;

   always #5 clk = ~clk;

   ahb_slave_mux #(
      .AHB_DATA_WIDTH (DW),
      .SLAVE_DEVICES  (NS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .bus_clk_in        (clk),
      .bus_rstn_in       (rstn),
      .slave_sel_in      (sel),
      .htrans_in         (htrans),
      .slave_rdata_in    (rdata_bus),
      .slave_ready_in    (rdy),
      .slave_resp_in     (rsp),
      .master_rdata_out  (m_rdata),
      .master_ready_out  (m_ready),
      .master_resp_out   (m_resp),
      .data_sel_out      (d_sel),
      .timeout_pulse_out (to_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_err_left = 0;
      m_idx      = -1;
      m_waits    = 0;
      m_pulse    = 1'b0;
   endtask

   task automatic drive(input logic [1:0] t, input logic [NS-1:0] s,
                        input logic [NS-1:0] r, input logic [NS-1:0] e);
      htrans = t;
      sel    = s;
      rdy    = r;
      rsp    = e;
      #1;
   endtask

   task automatic expect_bus(input string tag, input logic r, input logic e,
                             input logic [NS-1:0] s);
      chk({tag, ".ready"}, 32'(m_ready), 32'(r));
      chk({tag, ".resp"},  32'(m_resp),  32'(e));
      chk({tag, ".sel"},   32'(d_sel),   32'(s));
   endtask

   // Compare against the model for this cycle, then advance it across the edge.
   task automatic tick();
      logic          e_rdy;
      logic          e_rsp;
      logic [DW-1:0] e_rd;
      logic [NS-1:0] e_sel;
      bit            found;
      e_rdy = 1'b1;
      e_rsp = 1'b0;
      e_rd  = '0;
      e_sel = '0;
      if (m_err_left == 2) begin
         e_rdy = 1'b0;
         e_rsp = 1'b1;
      end else if (m_err_left == 1) begin
         e_rsp = 1'b1;
      end else if (m_idx >= 0) begin
         e_sel[m_idx] = 1'b1;
         e_rd  = rdata_bus[m_idx*DW +: DW];
         e_rdy = rdy[m_idx];
         e_rsp = rsp[m_idx];
      end
      chk("model.ready", 32'(m_ready), 32'(e_rdy));
      chk("model.resp",  32'(m_resp),  32'(e_rsp));
      chk("model.rdata", m_rdata, e_rd);
      chk("model.sel",   32'(d_sel), 32'(e_sel));
      chk("model.pulse", 32'(to_pulse), 32'(m_pulse));

      m_pulse = 1'b0;
      if (m_err_left == 2) begin
         m_err_left = 1;
      end else if (m_idx >= 0 && !rdy[m_idx]) begin
         m_waits++;
         if (TO > 0 && m_waits == int'(TO)) begin
            m_idx      = -1;
            m_err_left = 2;
            m_waits    = 0;
            m_pulse    = 1'b1;
         end
      end else begin
         m_err_left = 0;
         m_idx      = -1;
         if (htrans >= 2'd2) begin
            if (sel != '0) begin
               found = 1'b0;
               for (int i = 0; i < int'(NS); i++) begin
                  if (!found && sel[i]) begin
                     m_idx = i;
                     found = 1'b1;
                  end
               end
               m_waits = 0;
            end else begin
               m_err_left = 2;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int stall;
      rstn   = 1'b0;
      htrans = 2'd0;
      sel    = '0;
      rdy    = '1;
      rsp    = '0;
      for (int i = 0; i < int'(NS); i++) rdata_bus[i*DW +: DW] = {16'hA5A5, 16'(i)};
      model_reset();
      #1;
      expect_bus("reset", 1'b1, 1'b0, 4'b0000);
      chk("reset.rdata", m_rdata, 32'h0);
      chk("reset.pulse", 32'(to_pulse), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      // Idle after reset release
      drive(2'd0, 4'b0000, 4'b1111, 4'b0000);
      expect_bus("idle", 1'b1, 1'b0, 4'b0000);
      tick();

      // NONSEQ to slave 2
      drive(2'd2, 4'b0100, 4'b1111, 4'b0000);
      tick();
      drive(2'd0, 4'b0000, 4'b1111, 4'b0000);
      expect_bus("s2", 1'b1, 1'b0, 4'b0100);
      chk("s2.rdata", m_rdata, 32'hA5A5_0002);
      tick();

      // Unmapped access -> two-cycle ERROR
      drive(2'd2, 4'b0000, 4'b1111, 4'b0000);
      tick();
      drive(2'd0, 4'b0000, 4'b1111, 4'b0000);
      expect_bus("unmap.err1", 1'b0, 1'b1, 4'b0000);
      tick();
      expect_bus("unmap.err2", 1'b1, 1'b1, 4'b0000);
      tick();
      expect_bus("unmap.idle", 1'b1, 1'b0, 4'b0000);
      tick();

      // Slave 1 stalls for 20 cycles -> timeout after 16 wait states
      drive(2'd2, 4'b0010, 4'b1111, 4'b0000);
      tick();
      for (int k = 0; k < 16; k++) begin
         drive(2'd0, 4'b0000, 4'b1101, 4'b0000);
         expect_bus("to.wait", 1'b0, 1'b0, 4'b0010);
         tick();
      end
      expect_bus("to.err1", 1'b0, 1'b1, 4'b0000);
      chk("to.pulse1", 32'(to_pulse), 32'h1);
      tick();
      expect_bus("to.err2", 1'b1, 1'b1, 4'b0000);
      chk("to.pulse2", 32'(to_pulse), 32'h0);
      tick();
      repeat (2) begin
         expect_bus("to.ignored", 1'b1, 1'b0, 4'b0000);
         tick();
      end

      // Slave 3 with 2 wait states, then SEQ to slave 0 without a bubble
      drive(2'd2, 4'b1000, 4'b1111, 4'b0000);
      tick();
      repeat (2) begin
         drive(2'd3, 4'b0001, 4'b0111, 4'b0000);
         expect_bus("s3.wait", 1'b0, 1'b0, 4'b1000);
         tick();
      end
      drive(2'd3, 4'b0001, 4'b1111, 4'b0000);
      expect_bus("s3.done", 1'b1, 1'b0, 4'b1000);
      chk("s3.rdata", m_rdata, 32'hA5A5_0003);
      tick();
      drive(2'd2, 4'b0110, 4'b1111, 4'b0000);
      expect_bus("s0", 1'b1, 1'b0, 4'b0001);
      tick();
      drive(2'd0, 4'b0000, 4'b1111, 4'b0000);
      expect_bus("multihot", 1'b1, 1'b0, 4'b0010);
      tick();

      // Asynchronous reset during ERR1
      drive(2'd2, 4'b0000, 4'b1111, 4'b0000);
      tick();
      drive(2'd0, 4'b0000, 4'b1111, 4'b0000);
      expect_bus("rst.err1", 1'b0, 1'b1, 4'b0000);
      rstn = 1'b0;
      #1;
      expect_bus("rst.mid", 1'b1, 1'b0, 4'b0000);
      chk("rst.rdata", m_rdata, 32'h0);
      model_reset();
      rstn = 1'b1;
      drive(2'd2, 4'b0100, 4'b1111, 4'b0000);
      tick();
      drive(2'd0, 4'b0000, 4'b1111, 4'b0000);
      expect_bus("rst.after", 1'b1, 1'b0, 4'b0100);
      tick();

      // Randomized traffic with occasional long stall bursts
      stall = 0;
      for (int c = 0; c < 600; c++) begin
         logic [NS-1:0] r;
         logic [NS-1:0] e;
         logic [NS-1:0] s;
         for (int i = 0; i < int'(NS); i++) rdata_bus[i*DW +: DW] = $urandom;
         if (stall == 0 && $urandom_range(0, 49) == 0) stall = $urandom_range(8, 22);
         for (int i = 0; i < int'(NS); i++) begin
            r[i] = ($urandom_range(0, 9) < 8);
            e[i] = ($urandom_range(0, 9) == 0);
         end
         if (stall > 0) begin
            r = '0;
            stall--;
         end
         s = NS'($urandom);
         if ($urandom_range(0, 4) == 0) s = '0;
         drive(2'($urandom_range(0, 3)), s, r, e);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mux.md
Name: ahb_slave_mux

Overview:
- AHB response-side multiplexer and default slave, downstream of the address decoder.
- Takes the decoder's address-phase one-hot slave select and registers it into a data-phase select.
- Uses the data-phase select to route the selected slave's read data, HREADYOUT and HRESP back to the master.
- Generates the two-cycle ERROR response for unmapped accesses and for slaves that stall past a wait-state timeout.

Parameters:
- AHB_DATA_WIDTH, 32: read data bus width.
- SLAVE_DEVICES, 4: number of slave ports; matches the decoder select width.
- TIMEOUT_CYCLES, 16: maximum consecutive wait states before a forced ERROR. 0 disables the timeout.

Ports:
- bus_clk_in  in  1  AHB clock (HCLK).
- bus_rstn_in  in  1  reset, asynchronous, active-low.
- slave_sel_in  in  SLAVE_DEVICES  address-phase one-hot select from the decoder; all-zero means unmapped.
- htrans_in  in  2  HTRANS of the current address phase (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- slave_rdata_in  in  SLAVE_DEVICES*AHB_DATA_WIDTH  packed read data; slave i at [i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH].
- slave_ready_in  in  SLAVE_DEVICES  per-slave HREADYOUT.
- slave_resp_in  in  SLAVE_DEVICES  per-slave HRESP (1 = ERROR).
- master_rdata_out  out  AHB_DATA_WIDTH  HRDATA to the master.
- master_ready_out  out  1  HREADY to the master and to all slaves.
- master_resp_out  out  1  HRESP to the master.
- data_sel_out  out  SLAVE_DEVICES  registered data-phase one-hot select.
- timeout_pulse_out  out  1  one-cycle pulse when a timeout fires.

Behaviour:

Reset (bus_rstn_in low, asynchronous, takes effect immediately including mid-transfer):
- state = IDLE_DP, data_sel_out = 0, wait counter = 0, timeout_pulse_out = 0.
- Outputs: master_ready_out = 1, master_resp_out = 0, master_rdata_out = 0.

States: IDLE_DP, SLAVE_DP, ERR1, ERR2.

Output decode (combinational from state):
- IDLE_DP: ready 1, resp 0, rdata 0.
- SLAVE_DP: rdata, ready and resp are those of the slave indexed by data_sel_out.
- ERR1: ready 0, resp 1, rdata 0.
- ERR2: ready 1, resp 1, rdata 0.

Address sampling (posedge where master_ready_out == 1, i.e. in IDLE_DP, ERR2, or SLAVE_DP with the selected slave ready):
- htrans_in is IDLE or BUSY: next state IDLE_DP, data_sel <= 0.
- htrans_in is NONSEQ or SEQ and slave_sel_in != 0: next state SLAVE_DP; data_sel <= lowest set bit of slave_sel_in (multi-hot is resolved by lowest-index priority); wait counter <= 0.
- htrans_in is NONSEQ or SEQ and slave_sel_in == 0: next state ERR1, data_sel <= 0.

Fixed transitions:
- ERR1 -> ERR2 unconditionally.
- ERR2 samples the next address phase by the rules above, so back-to-back errors are legal.

Timeout (TIMEOUT_CYCLES > 0):
- In SLAVE_DP with the selected slave's ready = 0: if wait counter == TIMEOUT_CYCLES-1, then next state ERR1, data_sel <= 0, counter <= 0, and timeout_pulse_out = 1 for exactly the first ERR1 cycle. Otherwise counter increments.
- Counter width is $clog2(TIMEOUT_CYCLES+1).
- The stalled slave's later ready/resp is ignored once the select is cleared.

Slave ERROR handling:
- A slave's own ERROR response in SLAVE_DP passes through unchanged; the slave sequences its two cycles.
- The mux samples a new address only on the cycle where the passed-through ready is 1.

Latency:
- data_sel_out changes one clock after the address phase completes.
- Response paths are combinational from state/select to the master (zero added latency).

Test Plan:
- Reset held, then released with htrans_in=0 -> ready=1, resp=0, rdata=0, data_sel_out=0000.
- NONSEQ with slave_sel_in=0100, slave2 rdata=0xA5A5_0002, ready=1 -> next cycle data_sel_out=0100, master_rdata_out=0xA5A5_0002, ready=1, resp=0.
- NONSEQ with slave_sel_in=0000 -> cycle+1: ready=0, resp=1; cycle+2: ready=1, resp=1; a following IDLE -> ready=1, resp=0.
- slave1 selected, holds ready=0 for 20 cycles (TIMEOUT_CYCLES=16) -> ready low for 16 cycles, then ERR1 with timeout_pulse_out=1 for one cycle, then ERR2, data_sel_out=0000.
- slave3 selected, 2 wait states, then a SEQ to slave0 presented while ready=1 -> data_sel_out switches 1000 -> 0001 on the next edge with no bubble; slave_sel_in=0110 -> data_sel_out=0010.
- bus_rstn_in pulsed low during ERR1 -> immediate ready=1, resp=0, data_sel_out=0000; the next NONSEQ is decoded normally.
